// File: rtl/dma_responder.sv
// -----------------------------------------------------------------------------
// dma_responder
//
// Slave side of a simple DMA initiator interface. One request moves a block of
// 16-byte beats between the initiator and a word-addressed host memory port.
//   dma_rwn = 1 : host memory -> initiator (read beats from hmem)
//   dma_rwn = 0 : initiator -> host memory (write beats to hmem)
// The byte address is truncated to a beat address, and the byte length is
// rounded up to whole beats.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   dma_req / dma_ready  request handshake (ready only while idle)
//   dma_rwn              transfer direction
//   dma_hostAddr         host byte address (low 4 bits ignored)
//   dma_transferLength   transfer length in bytes
//   dma_writeData        write beat from initiator (beat k+1 follows ack k)
//   dma_readData         read beat to initiator; holds when dma_ack = 0
//   dma_ack              one beat moved this cycle
//   hmem_en/we/addr      host memory request (word address)
//   hmem_wdata           host memory write data
//   hmem_rdata           host memory read data, valid 1 cycle after acceptance
//   hmem_ready           host memory accepts the current request
//   xfer_done            one-cycle pulse when a transfer completes
// -----------------------------------------------------------------------------
module dma_responder #(
    parameter int DATA_W  = 128,
    parameter int HOST_AW = 40,
    parameter int LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dma_req,
    output logic                 dma_ready,
    input  logic                 dma_rwn,
    input  logic [HOST_AW-1:0]   dma_hostAddr,
    input  logic [LEN_W-1:0]     dma_transferLength,
    input  logic [DATA_W-1:0]    dma_writeData,
    output logic [DATA_W-1:0]    dma_readData,
    output logic                 dma_ack,
    output logic                 hmem_en,
    output logic                 hmem_we,
    output logic [HOST_AW-5:0]   hmem_addr,
    output logic [DATA_W-1:0]    hmem_wdata,
    input  logic [DATA_W-1:0]    hmem_rdata,
    input  logic                 hmem_ready,
    output logic                 xfer_done
);

    localparam int WA_W  = HOST_AW - 4;
    // Beat count for a full-scale length (2^LEN_W - 1 bytes) needs LEN_W-3 bits.
    localparam int CNT_W = LEN_W - 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_LAST,
        WR,
        DONE
    } state_t;

    state_t              state_reg;
    logic [WA_W-1:0]     addr_reg;
    logic [CNT_W-1:0]    remaining_reg;
    logic                ready_reg;
    logic                en_reg;
    logic                we_reg;
    logic                rd_ack_reg;
    logic                done_reg;
    logic [DATA_W-1:0]   rd_hold_reg;

    logic                handshake;
    logic [LEN_W:0]      len_round;
    logic [CNT_W-1:0]    beats;
    logic                len_zero;
    logic                beat_accept;
    logic                last_beat;
    logic                unused_bits;

    assign handshake   = dma_req & ready_reg;

    // ceil(len / 16) computed one bit wider so 0xFFFF rounds to 4096.
    assign len_round   = {1'b0, dma_transferLength} + (LEN_W + 1)'(15);
    assign beats       = len_round[LEN_W:4];
    assign len_zero    = (dma_transferLength == '0);

    assign beat_accept = en_reg & hmem_ready;
    assign last_beat   = (remaining_reg == CNT_W'(1));

    assign unused_bits = ^{len_round[3:0], dma_hostAddr[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            ready_reg     <= 1'b0;
            en_reg        <= 1'b0;
            we_reg        <= 1'b0;
            rd_ack_reg    <= 1'b0;
            done_reg      <= 1'b0;
            rd_hold_reg   <= '0;
        end else begin
            rd_ack_reg <= 1'b0;
            done_reg   <= 1'b0;

            // The beat returned by memory this cycle becomes the held value.
            if (rd_ack_reg) begin
                rd_hold_reg <= hmem_rdata;
            end

            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        addr_reg      <= dma_hostAddr[HOST_AW-1:4];
                        remaining_reg <= beats;
                        ready_reg     <= 1'b0;
                        if (len_zero) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= dma_rwn ? RD : WR;
                            en_reg    <= 1'b1;
                            we_reg    <= ~dma_rwn;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset.
                        ready_reg <= 1'b1;
                    end
                end

                RD: begin
                    if (beat_accept) begin
                        addr_reg      <= addr_reg + WA_W'(1);
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        rd_ack_reg    <= 1'b1;
                        if (last_beat) begin
                            state_reg <= RD_LAST;
                            en_reg    <= 1'b0;
                        end
                    end
                end

                // Final read data arrives here; its ack was scheduled in RD.
                RD_LAST: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end

                WR: begin
                    if (beat_accept) begin
                        addr_reg      <= addr_reg + WA_W'(1);
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        if (last_beat) begin
                            state_reg <= DONE;
                            en_reg    <= 1'b0;
                            we_reg    <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg <= IDLE;
                    en_reg    <= 1'b0;
                    we_reg    <= 1'b0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign dma_ready  = ready_reg;
    assign hmem_en    = en_reg;
    assign hmem_we    = we_reg;
    assign hmem_addr  = addr_reg;
    assign xfer_done  = done_reg;
    assign hmem_wdata = we_reg ? dma_writeData : '0;

    // Write beats are acknowledged in the cycle memory takes them; read beats
    // are acknowledged in the cycle their data comes back.
    assign dma_ack      = rd_ack_reg | (we_reg & beat_accept);
    assign dma_readData = rd_ack_reg ? hmem_rdata : rd_hold_reg;

endmodule

// File: doc/dma_responder.md
DMA_RESPONDER -- requirements
Module: dma_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning beat width in bits (16 bytes per beat).
REQ-002 SHALL have parameter HOST_AW, default 40, meaning host byte-address width.
REQ-003 SHALL have parameter LEN_W, default 16, meaning transfer-length width in bytes.
REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port dma_req  in  1  initiator requests a transfer.
REQ-007 SHALL have port dma_ready  out  1  responder accepts request this cycle.
REQ-008 SHALL have port dma_rwn  in  1  1 = host-to-local read, 0 = local-to-host write.
REQ-009 SHALL have port dma_hostAddr  in  HOST_AW  host byte address.
REQ-010 SHALL have port dma_transferLength  in  LEN_W  length in bytes.
REQ-011 SHALL have port dma_writeData  in  DATA_W  write beat from initiator.
REQ-012 SHALL have port dma_readData  out  DATA_W  read beat to initiator.
REQ-013 SHALL have port dma_ack  out  1  one beat transferred this cycle.
REQ-014 SHALL have ports hmem_en out 1, hmem_we out 1, hmem_addr out HOST_AW-4, hmem_wdata out DATA_W, hmem_rdata in DATA_W, hmem_ready in 1: host memory port, word-addressed, read data valid exactly 1 cycle after an accepted read.
REQ-015 SHALL have port xfer_done  out  1  one-cycle pulse at transfer end.

Function
REQ-016 SHALL implement states IDLE, RD, RD_LAST, WR, DONE.
REQ-017 SHALL drive dma_ready=1 only in IDLE; handshake = dma_req & dma_ready.
REQ-018 On handshake SHALL latch word address = dma_hostAddr[HOST_AW-1:4] (low 4 bits ignored) and beats = ceil(len/16), 13-bit counter, max 4096.
REQ-019 Handshake with length 0 SHALL go IDLE->DONE with no hmem access and no dma_ack.
REQ-020 Otherwise SHALL go to RD if dma_rwn=1, WR if 0.
REQ-021 RD: SHALL assert hmem_en=1, hmem_we=0 at current address; a read is accepted when hmem_ready=1; each acceptance increments address and decrements remaining.
REQ-022 RD: each accepted read SHALL produce dma_ack=1 with dma_readData=hmem_rdata in the following cycle; sustained hmem_ready gives one beat per cycle.
REQ-023 RD: after the last read is accepted SHALL go RD_LAST (hmem_en=0), emit the final ack, then DONE.
REQ-024 WR: SHALL assert hmem_en=1, hmem_we=1, hmem_wdata=dma_writeData; when hmem_ready=1 SHALL assert dma_ack=1 the same cycle, increment address, decrement remaining.
REQ-025 WR: initiator presents beat k+1 the cycle after ack of beat k; the responder SHALL not assume valid data beyond that rule.
REQ-026 WR: after last acked beat SHALL go DONE.
REQ-027 DONE: SHALL pulse xfer_done=1 for one cycle, then IDLE; dma_ready=0 in DONE.
REQ-028 dma_req asserted outside IDLE SHALL be ignored; a still-high dma_req is accepted on return to IDLE.
REQ-029 hmem_ready=0 SHALL stall without losing or duplicating beats; no dma_ack for stalled cycles.
REQ-030 Address SHALL wrap modulo 2^(HOST_AW-4) without error.
REQ-031 dma_readData SHALL hold its last value when dma_ack=0.

Reset
REQ-032 rst=1 SHALL force, asynchronously, state IDLE, counters 0, dma_ready=0, dma_ack=0, dma_readData=0, hmem_en=0, hmem_we=0, hmem_addr=0, xfer_done=0.
REQ-033 dma_ready SHALL rise the first clk edge after rst deasserts.
REQ-034 rst mid-transfer SHALL abort; no xfer_done; next transfer starts clean.

Verification
REQ-035 Read hostAddr=0x0080004080, len=0x30, hmem_ready=1 -> hmem_addr 0x008000408,409,40A; 3 consecutive dma_ack with model data; xfer_done 1 cycle after last ack.
REQ-036 Write len=0x20, data 0x1234 then 0x5678, hmem_ready=1 -> 2 hmem writes at base, base+1, 2 acks, xfer_done.
REQ-037 Read len=0x31 with hmem_ready low every other cycle -> 4 reads, 4 acks, order preserved, no duplicates.
REQ-038 len=0 -> no hmem_en, no dma_ack, xfer_done 1 cycle after handshake.
REQ-039 hostAddr=0xFFFFFFFFF0, read len=0x20 -> addresses 0xFFFFFFFFF then 0x000000000.
REQ-040 rst pulse after 2 of 4 write beats -> all outputs zero immediately, dma_ready=1 next edge, following 1-beat read completes correctly.
